// File: rtl/whatever.sv
// whatever: 1024x16 instruction RAM, instruction register and main-control decode.
// Define WHATEVER_OUTREG_EN to register the seven control strobes (2-cycle address-to-control latency).
module whatever (
   input  logic        clock,
   input  logic        reset,
   input  logic [9:0]  addra,
   input  logic [15:0] dina,
   input  logic        wea,
   output logic        alusrc,
   output logic        memtoreg,
   output logic        regdest,
   output logic        regwrite,
   output logic        memread,
   output logic        memwrite,
   output logic        branch
);
   logic [15:0] mem [0:1023];
   logic [15:0] ir;
   logic [3:0]  opcode;
   logic [6:0]  dec;
   logic [6:0]  ctrl;
   logic        unused_ir;
   always_ff @(posedge clock)
      if (wea) mem[addra] <= dina;
   always_ff @(posedge clock)
      if (reset) ir <= 16'h0000;
      else ir <= wea ? dina : mem[addra];
   assign opcode = ir[15:12];
   // operand fields belong to later stages; only the opcode matters here
   assign unused_ir = ^ir[11:0];
   // {alusrc, memtoreg, regdest, regwrite, memread, memwrite, branch}
   always_comb begin
      dec = opcode == 4'h1 ? 7'b0011000 :
            opcode == 4'h2 ? 7'b1001000 :
            opcode == 4'h3 ? 7'b1101100 :
            opcode == 4'h4 ? 7'b1000010 :
            (opcode == 4'h5 || opcode == 4'h6) ? 7'b0000001 : 7'b0000000;
   end
`ifdef WHATEVER_OUTREG_EN
   always_ff @(posedge clock)
      if (reset) ctrl <= 7'b0;
      else ctrl <= dec;
`else
   assign ctrl = dec;
`endif
   assign {alusrc, memtoreg, regdest, regwrite, memread, memwrite, branch} = ctrl;
endmodule

// File: tb/tb_whatever.sv
// tb_whatever: table-driven and randomized checks of fetch/decode against an opcode-rule model.
module tb_whatever;
`ifdef WHATEVER_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [6:0] NOP = 7'b0000000, RT = 7'b0011000, ADDI = 7'b1001000,
                          LW = 7'b1101100, SW = 7'b1000010, BR = 7'b0000001;
   logic clock = 0, reset = 1, wea = 0;
   logic [9:0] addra = 0;
   logic [15:0] dina = 0;
   logic alusrc, memtoreg, regdest, regwrite, memread, memwrite, branch;
   logic [6:0] ctrl;
   int total = 0, bad = 0;
   logic [15:0] ref_mem [0:1023];
   bit ref_known [0:1023];
   logic [15:0] prev_word = 0;
   bit prev_known = 1;
   logic [6:0] pend;
   bit pend_v = 0;
   string pend_nm;

   typedef struct {
      logic       rst;
      logic       we;
      logic [9:0] a;
      logic [15:0] d;
      logic [6:0] k;
      string      nm;
   } vec_t;
   vec_t tbl [$];

   whatever dut (.clock(clock), .reset(reset), .addra(addra), .dina(dina), .wea(wea),
                 .alusrc(alusrc), .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite),
                 .memread(memread), .memwrite(memwrite), .branch(branch));
   assign ctrl = {alusrc, memtoreg, regdest, regwrite, memread, memwrite, branch};

   always #5 clock = ~clock;

   function automatic logic [6:0] model_ctrl(input logic [15:0] w);
      int op = int'(w[15:12]);
      bit rtype = op == 1, addi = op == 2, load = op == 3, store = op == 4, br = op == 5 || op == 6;
      return {addi || load || store, load, rtype, rtype || addi || load, load, store, br};
   endfunction

   task automatic cmp(input string nm, input logic [6:0] act, input logic [6:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, want);
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [9:0] a, input logic [15:0] d,
                       input bit chk, input logic [6:0] k, input string nm);
      logic [15:0] word;
      bit known;
      logic [6:0] e;
      bit e_known;
      reset = r; wea = w; addra = a; dina = d;
      @(posedge clock); #1;
      known = r || w || ref_known[a];
      word = r ? 16'h0 : w ? d : ref_mem[a];
      if (w) begin
         ref_mem[a] = d;
         ref_known[a] = 1;
      end
      if (LAT == 1) begin
         e = model_ctrl(word); e_known = known;
      end else begin
         e = r ? NOP : model_ctrl(prev_word); e_known = r || prev_known;
      end
      prev_word = word; prev_known = known;
      if (e_known) cmp("model", ctrl, e);
      total++;
      if ((memread && memwrite) || (regwrite && memwrite)) begin
         bad++;
         $display("FAIL exclusive_strobes: got %b want no rd+wr or regwr+memwr", ctrl);
      end
      if (LAT == 1) begin
         if (chk) cmp(nm, ctrl, k);
      end else begin
         if (pend_v) cmp(pend_nm, ctrl, pend);
         pend_v = chk; pend = k; pend_nm = nm;
      end
   endtask

   initial begin
      foreach (ref_known[i]) ref_known[i] = 0;
      tbl.push_back('{0, 1, 10'd0, 16'h1234, RT, "wr0_rtype"});
      tbl.push_back('{0, 1, 10'd1, 16'h2ABC, ADDI, "wr1_addi"});
      tbl.push_back('{0, 1, 10'd2, 16'h3001, LW, "wr2_lw"});
      tbl.push_back('{0, 1, 10'd3, 16'h4002, SW, "wr3_sw"});
      tbl.push_back('{0, 1, 10'd4, 16'h5FFF, BR, "wr4_beq"});
      tbl.push_back('{0, 1, 10'd5, 16'h6000, BR, "wr5_bne"});
      tbl.push_back('{0, 1, 10'd6, 16'h9999, NOP, "wr6_rsvd"});
      tbl.push_back('{0, 0, 10'd0, 16'h0000, RT, "rd0_rtype"});
      tbl.push_back('{0, 0, 10'd1, 16'hFFFF, ADDI, "rd1_addi"});
      tbl.push_back('{0, 0, 10'd2, 16'h0000, LW, "rd2_lw"});
      tbl.push_back('{0, 0, 10'd3, 16'h0000, SW, "rd3_sw"});
      tbl.push_back('{0, 0, 10'd4, 16'h0000, BR, "rd4_beq"});
      tbl.push_back('{0, 0, 10'd5, 16'h0000, BR, "rd5_bne"});
      tbl.push_back('{0, 0, 10'd6, 16'h0000, NOP, "rd6_rsvd"});
      tbl.push_back('{0, 1, 10'd10, 16'h3000, LW, "wfirst_lw"});
      tbl.push_back('{0, 0, 10'd10, 16'h0000, LW, "wfirst_reread"});
      tbl.push_back('{0, 1, 10'd1023, 16'h4000, SW, "wr1023_sw"});
      tbl.push_back('{0, 1, 10'd0, 16'h1000, RT, "wr0_rtype2"});
      tbl.push_back('{0, 0, 10'd1023, 16'h0000, SW, "rd1023_sw"});
      tbl.push_back('{0, 0, 10'd0, 16'h0000, RT, "rd0_noalias"});

      for (int i = 0; i < 3; i++) step(1, 0, 10'($urandom), 16'h0, 1, NOP, "reset_hold");
      step(0, 0, 10'd700, 16'h0, 0, NOP, "");
      if (LAT == 2) cmp("post_reset", ctrl, NOP);

      foreach (tbl[i]) step(tbl[i].rst, tbl[i].we, tbl[i].a, tbl[i].d, 1, tbl[i].k, tbl[i].nm);

      step(0, 0, 10'd2, 16'h0, 0, NOP, "");
      step(1, 1, 10'd20, 16'h2000, 0, NOP, "");
      cmp("reset_mid", ctrl, NOP);
      step(0, 0, 10'd20, 16'h0, 0, NOP, "");
      if (LAT == 1) cmp("rst_write_addi", ctrl, ADDI);
      else cmp("rst_write_pipe_nop", ctrl, NOP);
      step(0, 0, 10'd20, 16'h0, 0, NOP, "");
      cmp("rst_write_addi2", ctrl, ADDI);

      for (int i = 0; i < 300; i++) begin
         logic [9:0] a;
         a = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 31));
         step($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, a, 16'($urandom), 0, NOP, "");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
